iter_mult_div: RTL and testbench
================================

Name: iter_mult_div

Overview:
Multicycle iterative multiply/divide unit for the MIPS datapath. It implements MULT, MULTU, DIV and DIVU.
- Issued by the control unit with a start/done handshake; results go to the Hi/Lo registers.
- Parametrised operand width, signed and unsigned modes, and divide-by-zero reporting.
- The control unit stalls on busy and polls done.

Parameters:
WIDTH, 32, operand width in bits; Hi and Lo are each WIDTH bits.
CNT_W, $clog2(WIDTH+1), iteration counter width.

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
op_div  input  1  1 = divide, 0 = multiply
op_signed  input  1  1 = signed (MULT/DIV), 0 = unsigned (MULTU/DIVU)
a  input  WIDTH  multiplicand / dividend (rs)
b  input  WIDTH  multiplier / divisor (rt)
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse; hi/lo valid from this cycle
hi  output  WIDTH  product upper half / remainder
lo  output  WIDTH  product lower half / quotient
div_by_zero  output  1  set with done when op_div=1 and b=0; held until the next accepted start

Behaviour:
- Reset: state=IDLE, busy=0, done=0, hi=0, lo=0, div_by_zero=0, counter=0. Reset mid-operation aborts immediately with the same values; no partial results are written.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - On start=1, latch op_div, op_signed and the operand magnitudes (two's-complement abs when op_signed, raw otherwise), plus sign flags. Clear div_by_zero.
  - If op_div=1 and b=0: go to DONE with div_by_zero=1, hi/lo unchanged.
  - Otherwise go to CALC with counter=0.
- CALC: one iteration per cycle, WIDTH iterations, then go to FIX.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring, one quotient bit per cycle.
- FIX: apply sign correction, write hi/lo, go to DONE.
  - Product is negated when sign_a XOR sign_b.
  - Quotient is negated when sign_a XOR sign_b; remainder takes the sign of the dividend.
- DONE: done=1 for exactly one cycle, then return to IDLE.
- Latency, with the start edge as edge 0:
  - Normal operation: done is high in the cycle after edge WIDTH+1, i.e. WIDTH+2 cycles; busy drops after edge WIDTH+2.
  - Divide-by-zero: done is high in the cycle after edge 0.
- start while busy: ignored, no queueing.
- start in the same cycle as reset: reset wins.
- Operands may change after the start edge without affecting the result.
- Signed overflow 0x80..0 / -1 (all-ones): lo=0x80..0, hi=0, no flag (wrap).
- hi/lo hold their last result until the next FIX or reset.

Optional Feature:
ITER_MULT_DIV_EARLY_TERM_EN
- Defined: a multiply leaves CALC once the remaining multiplier magnitude bits are all zero, after a minimum of 1 iteration. Latency is then data-dependent, from 3 to WIDTH+2 cycles; results are bit-identical.
- Undefined: fixed WIDTH iterations for every operation. Divide latency is unaffected in both cases.

Decomposition:
- Package mult_div_pkg: state enum (IDLE, CALC, FIX, DONE), abs/negate helper function parametrised by width, and the op encoding constants OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, given as {op_div, op_signed}.
- No sub-module: the datapath is a single accumulator register plus an adder/subtractor and fits in one module.

Test Plan (WIDTH=32):
- MULT a=0xFFFFFFFD, b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; done exactly 34 cycles after the start edge, busy high throughout.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; div_by_zero=0.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 -> lo=14, hi=2.
- DIVU a=100, b=0 after a prior result hi=2, lo=14 -> done in the next cycle, div_by_zero=1, hi=2, lo=14 unchanged. A following valid start clears the flag.
- Start pulse at cycle 5 of a busy MULT -> ignored, original result unaffected. Reset at cycle 10 of a DIV -> busy=0, hi=lo=0, done never pulses, and the next start completes correctly.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. With ITER_MULT_DIV_EARLY_TERM_EN, MULTU 5*1 -> done 3 cycles after start, lo=5.

Source files
------------

// File: rtl/mult_div_pkg.sv
// mult_div_pkg: shared FSM states, op encodings and the sign helper for iter_mult_div
package mult_div_pkg;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam int MAX_W = 128;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    // Width-generic negate/abs: callers zero-extend into MAX_W bits and cast the
    // result back to their own width; the low bits are the two's complement.
    function automatic logic [MAX_W-1:0] neg_if(input logic [MAX_W-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

endpackage

// File: rtl/iter_mult_div.sv
// iter_mult_div: multicycle MULT/MULTU/DIV/DIVU unit writing Hi/Lo; optional ITER_MULT_DIV_EARLY_TERM_EN
module iter_mult_div
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_div,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    state_t             state, nstate;
    logic [CNT_W-1:0]   cnt;
    logic               opd, sa, sb;
    logic [2*WIDTH-1:0] acc, mc;
    logic [WIDTH-1:0]   mq;
    logic [WIDTH-1:0]   ma, mb, quo, rem;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     shifted, trial;
    logic               last;

    // operand magnitudes, restoring-divide trial subtract and sign-corrected results
    always_comb begin
        ma      = WIDTH'(neg_if(MAX_W'(a), op_signed & a[WIDTH-1]));
        mb      = WIDTH'(neg_if(MAX_W'(b), op_signed & b[WIDTH-1]));
        shifted = {acc[WIDTH-1:0], mq[WIDTH-1]};
        trial   = shifted - {1'b0, mc[WIDTH-1:0]};
        prod    = (2*WIDTH)'(neg_if(MAX_W'(acc), sa ^ sb));
        quo     = WIDTH'(neg_if(MAX_W'(mq), sa ^ sb));
        rem     = WIDTH'(neg_if(MAX_W'(acc[WIDTH-1:0]), sa));
`ifdef ITER_MULT_DIV_EARLY_TERM_EN
        last    = (cnt == CNT_W'(WIDTH - 1)) || (!opd && (mq >> 1) == '0);
`else
        last    = cnt == CNT_W'(WIDTH - 1);
`endif
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= nstate;
    end

    // next state and status outputs
    always_comb begin
        nstate = state == IDLE ? (start ? ((op_div && b == '0) ? DONE : CALC) : IDLE) :
                 state == CALC ? (last ? FIX : CALC) :
                 state == FIX  ? DONE : IDLE;
        busy   = state != IDLE;
        done   = state == DONE;
    end

    // operand capture, one shift-add or restoring-divide step per CALC cycle, Hi/Lo write in FIX
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            opd         <= 1'b0;
            sa          <= 1'b0;
            sb          <= 1'b0;
            acc         <= '0;
            mc          <= '0;
            mq          <= '0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    opd         <= op_div;
                    sa          <= op_signed & a[WIDTH-1];
                    sb          <= op_signed & b[WIDTH-1];
                    div_by_zero <= op_div && b == '0;
                    cnt         <= '0;
                    acc         <= '0;
                    mc          <= (2*WIDTH)'(op_div ? mb : ma);
                    mq          <= op_div ? ma : mb;
                end
                CALC: begin
                    cnt <= cnt + CNT_W'(1);
                    if (opd) begin
                        acc <= (2*WIDTH)'(trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0]);
                        mq  <= {mq[WIDTH-2:0], ~trial[WIDTH]};
                    end else begin
                        acc <= acc + (mq[0] ? mc : '0);
                        mc  <= mc << 1;
                        mq  <= mq >> 1;
                    end
                end
                FIX: begin
                    if (opd) begin
                        lo <= quo;
                        hi <= rem;
                    end else
                        {hi, lo} <= prod;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_mult_div.sv
// tb_iter_mult_div: directed and random scoreboard checks of iter_mult_div (WIDTH=32)
module tb_iter_mult_div;

    logic        clk, reset, start, op_div, op_signed;
    logic [31:0] a, b, hi, lo;
    logic        busy, done, div_by_zero;

    int total = 0;
    int bad   = 0;
    logic [64:0] sbq[$];
    logic [31:0] lhi = 0, llo = 0;

    iter_mult_div #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op_div(op_div), .op_signed(op_signed),
        .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string t, input logic [63:0] o, input logic [63:0] x);
        total++;
        assert (o === x) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", t, o, x);
        end
    endtask

    // {div_by_zero, hi, lo} from plain SV arithmetic
    function automatic logic [64:0] model(input logic d, s, input logic [31:0] x, y);
        logic signed [63:0] px, py;
        logic signed [31:0] sx, sy;
        logic [63:0] p;
        if (d && y == 0) return {1'b1, lhi, llo};
        if (!d) begin
            px = s ? {{32{x[31]}}, x} : {32'b0, x};
            py = s ? {{32{y[31]}}, y} : {32'b0, y};
            p = px * py;
            return {1'b0, p};
        end
        if (!s) return {1'b0, x % y, x / y};
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {1'b0, 32'h0, 32'h80000000};
        sx = x; sy = y;
        return {1'b0, 32'(sx % sy), 32'(sx / sy)};
    endfunction

    // clock edges from the start edge up to and including the one after which done is high
    function automatic int exp_lat(input logic d, s, input logic [31:0] y);
        logic [31:0] m;
        int it;
        m = (s && y[31]) ? -y : y;
        if (d && y == 0) return 1;
        it = 32;
`ifdef ITER_MULT_DIV_EARLY_TERM_EN
        if (!d) begin
            it = 1;
            for (int i = 0; i < 32; i++) if (m[i]) it = i + 1;
        end
`endif
        return it + 2;
    endfunction

    task automatic run(input logic d, s, input logic [31:0] x, y, input int poke_at, input int rst_at);
        logic [64:0] e;
        int n, lat, pulses;
        bit bz;
        e = model(d, s, x, y);
        lat = exp_lat(d, s, y);
        sbq.push_back(e);
        start = 1; op_div = d; op_signed = s; a = x; b = y;
        @(negedge clk);
        start = 0; a = $urandom; b = $urandom; op_div = ~d; op_signed = ~s;
        n = 1; bz = 1;
        while (!done && n < 200) begin
            if (!busy) bz = 0;
            if (n == rst_at) begin
                reset = 1;
                @(negedge clk);
                reset = 0;
                void'(sbq.pop_front());
                lhi = 0; llo = 0;
                chk("rst_busy", busy, 0);
                chk("rst_hi", hi, 0);
                chk("rst_lo", lo, 0);
                chk("rst_dbz", div_by_zero, 0);
                pulses = 0;
                repeat (40) begin
                    @(negedge clk);
                    if (done) pulses++;
                end
                chk("rst_nodone", pulses, 0);
                return;
            end
            if (n == poke_at) begin
                start = 1; op_div = 1; b = 0;
            end else
                start = 0;
            @(negedge clk);
            n++;
        end
        start = 0;
        chk("busy_thru", bz & busy, 1);
        chk("latency", n, lat);
        e = sbq.pop_front();
        if (done) begin
            chk("hi", hi, e[63:32]);
            chk("lo", lo, e[31:0]);
            chk("dbz", div_by_zero, e[64]);
            lhi = e[63:32]; llo = e[31:0];
        end
        @(negedge clk);
        chk("idle", {busy, done}, 0);
        chk("dbz_hold", div_by_zero, e[64]);
    endtask

    initial begin
        reset = 1; start = 0; op_div = 0; op_signed = 0; a = 0; b = 0;
        repeat (3) @(negedge clk);
        chk("reset_state", {busy, done, div_by_zero, hi, lo}, 0);
        reset = 0;
        @(negedge clk);

        run(0, 1, 32'hFFFFFFFD, 32'd7, 0, 0);
        chk("mult_c", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
        run(0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
        chk("multu_c", {div_by_zero, hi, lo}, {1'b0, 64'hFFFFFFFE_00000001});
        run(1, 1, 32'hFFFFFFF9, 32'd2, 0, 0);
        chk("div_c", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        run(1, 0, 32'd100, 32'd7, 0, 0);
        chk("divu_c", {hi, lo}, {32'd2, 32'd14});
        run(1, 0, 32'd100, 32'd0, 0, 0);
        chk("dbz_c", {div_by_zero, hi, lo}, {1'b1, 32'd2, 32'd14});
        run(0, 0, 32'd3, 32'd4, 0, 0);
        chk("dbz_clear", {div_by_zero, lo}, {1'b0, 32'd12});

        run(0, 1, 32'd12345, -32'sd6789, 5, 0);
        run(1, 1, 32'hDEADBEEF, 32'd77, 0, 10);
        run(1, 0, 32'd1000, 32'd33, 0, 0);
        chk("post_rst", {hi, lo}, {32'd10, 32'd30});

        run(1, 1, 32'h80000000, 32'hFFFFFFFF, 0, 0);
        chk("ovf_c", {div_by_zero, hi, lo}, {1'b0, 32'h0, 32'h80000000});
        run(0, 0, 32'd5, 32'd1, 0, 0);
        chk("mul51_c", lo, 32'd5);

        start = 1; reset = 1; op_div = 0; a = 9; b = 9;
        @(negedge clk);
        start = 0; reset = 0;
        chk("rst_wins", {busy, hi, lo}, 0);
        lhi = 0; llo = 0;
        @(negedge clk);
        chk("rst_wins_idle", busy, 0);

        for (int i = 0; i < 8; i++) begin
            logic [31:0] x, y;
            x = $urandom;
            y = (i % 3 == 0) ? 32'($urandom_range(1, 500)) : $urandom;
            if (y == 0) y = 1;
            run(1'(i[1]), 1'(i[0]), x, y, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
